// File: rtl/timer_pkg.sv
// Shared definitions for the timer display path: seven-segment codes,
// conversion state encoding and default timing parameters.
package timer_pkg;

    localparam int DEF_CLK_HZ   = 100_000_000;
    localparam int DEF_SCAN_HZ  = 1000;
    localparam int DEF_BLINK_HZ = 2;

    // Width of the captured {mode, hour, min, sec} word.
    localparam int SHADOW_W = 19;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Conversion sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONV_HI = 2'd1,
        CONV_LO = 2'd2
    } disp_state_t;

    // BCD digit to segment pattern; anything above 9 is blanked.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 6-bit binary to two-digit BCD converter using repeated
// subtraction of ten. A value v completes floor(v/10)+1 cycles after start.
//
// Handshake: start_i is sampled only while busy_o is low; a start seen while
// busy is dropped. done_o pulses for exactly one cycle with tens_o/ones_o
// already valid, and busy_o is low in that same cycle, so a new start may be
// presented alongside the done pulse. Results hold until the next completion.
module bin2bcd_seq
    import timer_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       start_i,
    input  logic [5:0] value_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    logic       busy_q;
    logic       done_q;
    logic [5:0] rem_q;
    logic [3:0] tens_acc_q;
    logic [3:0] tens_res_q;
    logic [3:0] ones_res_q;

    // Subtract ten per cycle until the remainder is a single digit, then publish.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rem_q      <= 6'd0;
            tens_acc_q <= 4'd0;
            tens_res_q <= 4'd0;
            ones_res_q <= 4'd0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (start_i) begin
                    busy_q     <= 1'b1;
                    rem_q      <= value_i;
                    tens_acc_q <= 4'd0;
                end
            end else if (rem_q >= 6'd10) begin
                rem_q      <= rem_q - 6'd10;
                tens_acc_q <= tens_acc_q + 4'd1;
            end else begin
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                tens_res_q <= tens_acc_q;
                ones_res_q <= rem_q[3:0];
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign tens_o = tens_res_q;
    assign ones_o = ones_res_q;

endmodule

// File: rtl/timer_display.sv
// Four-digit multiplexed seven-segment driver for the countdown timer.
// Captures the timer fields glitch-free, converts the two displayed fields to
// BCD, scans them onto the display with a colon, and blinks 00:00 on expiry.
module timer_display
    import timer_pkg::*;
#(
    parameter int CLK_HZ   = DEF_CLK_HZ,
    parameter int SCAN_HZ  = DEF_SCAN_HZ,
    parameter int BLINK_HZ = DEF_BLINK_HZ
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [5:0] sec_i,
    input  logic [5:0] min_i,
    input  logic [5:0] hour_i,
    input  logic       mode_i,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic [3:0] an_o,
    output logic       done_o,
    output logic [1:0] dbg_state_o,
    output logic       dbg_pending_o
);

    localparam int SLOT_CYC = CLK_HZ / SCAN_HZ;
    localparam int HALF_CYC = CLK_HZ / (2 * BLINK_HZ);
    localparam int SLOT_W   = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int HALF_W   = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;

    // ------------------------------------------------------------------
    // Input capture
    // ------------------------------------------------------------------
    logic [SHADOW_W-1:0] in_word;
    logic [SHADOW_W-1:0] sample_q;
    logic [SHADOW_W-1:0] shadow_q;
    logic                sample_vld_q;
    logic                captured_q;
    logic                req_q;
    logic                done_q;
    logic                shadow_load;

    assign in_word = {mode_i, hour_i, min_i, sec_i};

    // The shadow only takes a sample that matched the live inputs for two
    // consecutive cycles, so a word caught mid-update never reaches it.
    assign shadow_load = sample_vld_q && (in_word == sample_q);

    // Sample, debounce into the shadow, and raise a request on any change.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
            shadow_q     <= '0;
            captured_q   <= 1'b0;
            req_q        <= 1'b0;
        end else begin
            sample_q     <= in_word;
            sample_vld_q <= 1'b1;
            req_q        <= shadow_load && (sample_q != shadow_q);
            if (shadow_load) begin
                shadow_q   <= sample_q;
                captured_q <= 1'b1;
            end
        end
    end

    // Expiry flag follows the shadow one cycle later, once a capture exists.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            done_q <= 1'b0;
        end else begin
            done_q <= captured_q && (shadow_q[17:0] == 18'd0);
        end
    end

    // Field selection: mode 0 shows MM:SS, mode 1 shows HH:MM.
    logic [5:0] hi_sel;
    logic [5:0] lo_sel;
    assign hi_sel = shadow_q[18] ? shadow_q[17:12] : shadow_q[11:6];
    assign lo_sel = shadow_q[18] ? shadow_q[11:6]  : shadow_q[5:0];

    // ------------------------------------------------------------------
    // Conversion sequencer
    // ------------------------------------------------------------------
    disp_state_t     state_q;
    disp_state_t     state_d;
    logic            pending_q;
    logic [5:0]      lo_snap_q;
    logic [3:0]      hi_tens_q;
    logic [3:0]      hi_ones_q;
    logic [3:0][3:0] digits_q;

    logic            conv_start;
    logic [5:0]      conv_value;
    logic            conv_busy;
    logic            conv_done;
    logic [3:0]      conv_tens;
    logic [3:0]      conv_ones;
    logic            snap_load;
    logic            hi_load;
    logic            digits_load;

    bin2bcd_seq u_conv (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .start_i  (conv_start),
        .value_i  (conv_value),
        .busy_o   (conv_busy),
        .done_o   (conv_done),
        .tens_o   (conv_tens),
        .ones_o   (conv_ones)
    );

    // Sequencer state register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and converter control. The low field is snapshotted at the
    // start of each pass so both halves of the digits come from one shadow.
    always_comb begin
        state_d     = state_q;
        conv_start  = 1'b0;
        conv_value  = hi_sel;
        snap_load   = 1'b0;
        hi_load     = 1'b0;
        digits_load = 1'b0;
        case (state_q)
            IDLE: begin
                if ((req_q || pending_q) && !conv_busy) begin
                    conv_start = 1'b1;
                    snap_load  = 1'b1;
                    state_d    = CONV_HI;
                end
            end
            CONV_HI: begin
                if (conv_done) begin
                    hi_load    = 1'b1;
                    conv_start = 1'b1;
                    conv_value = lo_snap_q;
                    state_d    = CONV_LO;
                end
            end
            CONV_LO: begin
                if (conv_done) begin
                    digits_load = 1'b1;
                    if (req_q || pending_q) begin
                        conv_start = 1'b1;
                        snap_load  = 1'b1;
                        state_d    = CONV_HI;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending flag, low-field snapshot and the atomic four-digit update.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pending_q <= 1'b0;
            lo_snap_q <= 6'd0;
            hi_tens_q <= 4'd0;
            hi_ones_q <= 4'd0;
            digits_q  <= '0;
        end else begin
            if (snap_load) begin
                pending_q <= 1'b0;
                lo_snap_q <= lo_sel;
            end else if (req_q && (state_q != IDLE)) begin
                pending_q <= 1'b1;
            end
            if (hi_load) begin
                hi_tens_q <= conv_tens;
                hi_ones_q <= conv_ones;
            end
            if (digits_load) begin
                digits_q <= {hi_tens_q, hi_ones_q, conv_tens, conv_ones};
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan and blink
    // ------------------------------------------------------------------
    logic [SLOT_W-1:0] scan_cnt_q;
    logic [1:0]        idx_q;
    logic              scan_tick;
    logic [HALF_W-1:0] blink_cnt_q;
    logic              blink_on_q;
    logic              lit;

    assign scan_tick = (scan_cnt_q == SLOT_W'(SLOT_CYC - 1));
    assign lit       = !scan_tick && blink_on_q;

    // Slot prescaler and digit index.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            scan_cnt_q <= '0;
            idx_q      <= 2'd0;
        end else if (scan_tick) begin
            scan_cnt_q <= '0;
            idx_q      <= idx_q + 2'd1;
        end else begin
            scan_cnt_q <= scan_cnt_q + SLOT_W'(1);
        end
    end

    // Blink phase: toggles every half-period while expired, parked on otherwise.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else if (!done_q) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else if (blink_cnt_q == HALF_W'(HALF_CYC - 1)) begin
            blink_cnt_q <= '0;
            blink_on_q  <= ~blink_on_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + HALF_W'(1);
        end
    end

    // Registered display outputs; anodes blank on slot ticks and off phases.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            seg_o <= SEG_BLANK;
            dp_o  <= 1'b1;
            an_o  <= 4'hF;
        end else begin
            seg_o <= seg_encode(digits_q[idx_q]);
            dp_o  <= !(lit && (idx_q == 2'd2));
            an_o  <= lit ? ~(4'b0001 << idx_q) : 4'hF;
        end
    end

    assign done_o        = done_q;
    assign dbg_state_o   = state_q;
    assign dbg_pending_o = pending_q;

endmodule
